// File: rtl/contador_pulsos_if.sv
// Board-side signal bundle for the push-button pulse counter: the button and
// switch inputs, plus the active-low segment and digit-enable drives.
interface contador_pulsos_if;
    logic boton;
    logic s0;
    logic s1;
    logic s2;
    logic s3;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic d0;
    logic d1;
    logic d2;
    logic d3;

    modport master (
        output boton, s0, s1, s2, s3,
        input  a, b, c, d, e, f, g,
        input  d0, d1, d2, d3
    );

    modport slave (
        input  boton, s0, s1, s2, s3,
        output a, b, c, d, e, f, g,
        output d0, d1, d2, d3
    );
endinterface

// File: rtl/contador_pulsos.sv
// Debounced push-button counter: 4-digit BCD up/down count with clear, hold
// and blank switches, shown on a multiplexed active-low 7-segment display.
module contador_pulsos #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic             clock,
    input  logic             reset,
    contador_pulsos_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Bit order {a,b,c,d,e,f,g}, 0 = segment lit.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Stage p0/p1: two-flop synchronisers, bit order {s3,s2,s1,s0,boton}
    logic [4:0] sync_p0;
    logic [4:0] sync_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {bus.s3, bus.s2, bus.s1, bus.s0, bus.boton};
            sync_p1 <= sync_p0;
        end
    end

    logic btn_sync;
    logic clr_sync;
    logic hold_sync;
    logic down_sync;
    logic blank_sync;

    assign btn_sync   = sync_p1[0];
    assign clr_sync   = sync_p1[1];
    assign hold_sync  = sync_p1[2];
    assign down_sync  = sync_p1[3];
    assign blank_sync = sync_p1[4];

    // Stage p2: debouncer and press edge detect
    logic [DB_W-1:0] db_cnt;
    logic            stable;
    logic            stable_q;
    logic            press;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt   <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
            if (btn_sync == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_q;

    // Stage p3: BCD count; presses during clear or hold are dropped
    logic [15:0] count_bcd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_bcd <= '0;
        end else if (clr_sync) begin
            count_bcd <= '0;
        end else if (!hold_sync && press) begin
            count_bcd <= down_sync ? bcd_dec(count_bcd) : bcd_inc(count_bcd);
        end
    end

    // Display scan, free-running and independent of the count path
    logic [RF_W-1:0] refresh_cnt;
    logic [1:0]      scan_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == RF_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    logic [3:0] digit_sel;
    logic [6:0] seg_n;
    logic [3:0] en_n;
    logic       blank;

    always_comb begin
        digit_sel = 4'd0;
        case (scan_idx)
            2'd0: digit_sel = count_bcd[3:0];
            2'd1: digit_sel = count_bcd[7:4];
            2'd2: digit_sel = count_bcd[11:8];
            2'd3: digit_sel = count_bcd[15:12];
            default: digit_sel = 4'd0;
        endcase
    end

    // The synchroniser is held clear during reset, so the raw switch blanks then.
    assign blank = blank_sync | (reset & bus.s3);
    assign seg_n = seg_decode(digit_sel);
    assign en_n  = blank ? 4'b1111 : ~(4'b0001 << scan_idx);

    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_n;
    assign {bus.d3, bus.d2, bus.d1, bus.d0}                  = en_n;
endmodule

// File: tb/tb_contador_pulsos.sv
// Self-checking bench for contador_pulsos: directed vectors, corner sequences
// and randomized presses scored against an arithmetic model of the count.
module tb_contador_pulsos;
    localparam int DB = 16;
    localparam int RF = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    contador_pulsos_if bus ();

    contador_pulsos #(
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_CYCLES (RF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int model_count = 0;

    typedef struct {
        bit s0;
        bit s1;
        bit s2;
        bit prs;
        int exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [6:0] segs();
        return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
    endfunction

    function automatic logic [3:0] ens();
        return {bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    function automatic int seg2dig(input logic [6:0] s);
        case (s)
            7'b0000001: return 0;
            7'b1001111: return 1;
            7'b0010010: return 2;
            7'b0000110: return 3;
            7'b1001100: return 4;
            7'b0100100: return 5;
            7'b0100000: return 6;
            7'b0001111: return 7;
            7'b0000000: return 8;
            7'b0000100: return 9;
            default:    return 15;
        endcase
    endfunction

    function automatic int active_idx(input logic [3:0] en);
        case (en)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_sw(input bit v0, input bit v1, input bit v2, input bit v3);
        bus.s0 = v0;
        bus.s1 = v1;
        bus.s2 = v2;
        bus.s3 = v3;
        cyc(4);
    endtask

    task automatic clean_press();
        bus.boton = 1'b1;
        cyc(24);
        bus.boton = 1'b0;
        cyc(24);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    // Collects one decoded digit per scan position, bounded to 40 cycles.
    task automatic read_display(output int val);
        int dig[4];
        bit seen[4];
        int nseen;
        int idx;
        nseen = 0;
        for (int i = 0; i < 4; i++) begin
            dig[i]  = 15;
            seen[i] = 1'b0;
        end
        for (int c = 0; c < 40 && nseen < 4; c++) begin
            @(negedge clock);
            idx = active_idx(ens());
            if (idx >= 0 && !seen[idx]) begin
                seen[idx] = 1'b1;
                nseen++;
                dig[idx] = seg2dig(segs());
            end
        end
        if (nseen < 4) val = -1;
        else val = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
    endtask

    task automatic wait_d0_start(output bit ok);
        logic [3:0] prev;
        logic [3:0] cur;
        prev = ens();
        ok   = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clock);
            cur = ens();
            if (prev[0] && !cur[0]) ok = 1'b1;
            prev = cur;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         v;
        int         t;
        int         n;
        bit         ok;
        bit         any_on;
        logic [3:0] exp_en;
        bit         r0, r1, r2, p;

        vecs[0]  = '{0, 0, 0, 1, 1};
        vecs[1]  = '{0, 0, 0, 1, 2};
        vecs[2]  = '{0, 0, 0, 1, 3};
        vecs[3]  = '{0, 1, 0, 1, 3};
        vecs[4]  = '{0, 0, 1, 1, 2};
        vecs[5]  = '{1, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 1, 9999};
        vecs[8]  = '{0, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 1, 1, 9999};
        vecs[10] = '{0, 0, 1, 1, 9998};
        vecs[11] = '{0, 1, 1, 1, 9998};

        bus.boton = 1'b0;
        bus.s0 = 1'b0;
        bus.s1 = 1'b0;
        bus.s2 = 1'b0;
        bus.s3 = 1'b1;
        reset  = 1'b1;
        #2;
        check("blank_in_reset", int'(ens()), 4'hF);
        bus.s3 = 1'b0;
        #1;
        check("reset_en", int'(ens()), 4'b1110);
        check("reset_seg", int'(segs()), 7'b0000001);
        cyc(2);
        reset = 1'b0;

        // Idle scan rotation: d1, d2, d3, d0, every digit showing "0"
        for (int k = 1; k <= 4; k++) begin
            cyc(RF);
            exp_en = 4'hF ^ (4'b0001 << (k % 4));
            check($sformatf("scan_en_%0d", k), int'(ens()), int'(exp_en));
            check($sformatf("scan_seg_%0d", k), int'(segs()), 7'b0000001);
        end

        bus.boton = 1'b1;
        cyc(10);
        bus.boton = 1'b0;
        cyc(30);
        read_display(v);
        check("short_glitch", v, 0);

        t = 0;
        while (t < 300) begin
            n = $urandom_range(1, 10);
            bus.boton = ~bus.boton;
            cyc(n);
            t += n;
        end
        bus.boton = 1'b1;
        cyc(40);
        bus.boton = 1'b0;
        cyc(40);
        read_display(v);
        check("bounce_count", v, 1);
        wait_d0_start(ok);
        check("bounce_d0_found", int'(ok), 1);
        check("bounce_d0_seg", int'(segs()), 7'b1001111);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_sw(vecs[i].s0, vecs[i].s1, vecs[i].s2, 1'b0);
            if (vecs[i].prs) clean_press();
            else cyc(48);
            read_display(v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // Clear lands within 3 cycles while d0 (showing 8) stays selected
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        wait_d0_start(ok);
        check("clear_d0_found", int'(ok), 1);
        bus.s0 = 1'b1;
        cyc(3);
        check("clear_fast_en", int'(ens()), 4'b1110);
        check("clear_fast_seg", int'(segs()), 7'b0000001);
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);

        set_sw(1'b0, 1'b0, 1'b0, 1'b1);
        any_on = 1'b0;
        bus.boton = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (ens() != 4'hF) any_on = 1'b1;
        end
        bus.boton = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clock);
            if (ens() != 4'hF) any_on = 1'b1;
        end
        check("blank_all_off", int'(any_on), 0);
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        read_display(v);
        check("blank_counted", v, 1);
        model_count = 1;

        for (int it = 0; it < 30; it++) begin
            r0 = ($urandom_range(0, 7) == 0);
            r1 = ($urandom_range(0, 3) == 0);
            r2 = 1'($urandom_range(0, 1));
            p  = ($urandom_range(0, 3) != 0);
            set_sw(r0, r1, r2, 1'b0);
            if (p) clean_press();
            else cyc(48);
            if (r0) model_count = 0;
            else if (p && !r1) model_count = r2 ? (model_count + 9999) % 10000
                                                : (model_count + 1) % 10000;
            read_display(v);
            check($sformatf("rand%0d", it), v, model_count);
        end

        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 && (model_count % 10) == 0; i++) begin
            clean_press();
            model_count = (model_count + 1) % 10000;
        end
        bus.boton = 1'b1;
        cyc(8);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_en", int'(ens()), 4'b1110);
        check("async_reset_seg", int'(segs()), 7'b0000001);
        cyc(2);
        reset = 1'b0;
        cyc(40);
        read_display(v);
        check("held_through_reset", v, 1);
        bus.boton = 1'b0;
        cyc(40);
        read_display(v);
        check("held_single_count", v, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
